// File: rtl/ccd_pkg.sv
// Shared types for the CCD pixel capture path: capture FSM states and the
// FIFO word carrying a pixel with its start/end-of-line markers.
package ccd_pkg;

   localparam int CCD_PIX_PERIOD = 50;
   localparam int CCD_ADC_W      = 16;

   typedef enum logic [1:0] {IDLE, LEAD, ACTIVE, TAIL} cap_state_t;

   typedef struct packed {
      logic [CCD_ADC_W-1:0] data;
      logic                 sol;
      logic                 eol;
   } pix_word_t;

endpackage

// File: rtl/ccd_pix_fifo.sv
// Synchronous FIFO of pix_word_t; a push into a full FIFO succeeds only when
// a pop frees the head slot in the same cycle.
module ccd_pix_fifo
   import ccd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic      clk_100M,
   input  logic      rst_n,
   input  logic      push,
   input  logic      pop,
   input  pix_word_t wr_word,
   output pix_word_t rd_word,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   pix_word_t       mem_q [FIFO_DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic            do_push, do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
      rd_word  = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_100M) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
   end

endmodule

// File: rtl/ccd_pixel_capture.sv
// CCD receive path: samples adc_data a fixed delay after each ccd_cp fall and
// streams active pixels with sol/eol. Define CCD_CDS_EN for correlated double sampling.
module ccd_pixel_capture
   import ccd_pkg::*;
#(
   parameter int ADC_W      = 16,
   parameter int DUMMY_LEAD = 32,
   parameter int ACTIVE_PIX = 7500,
   parameter int SAMPLE_DLY = 6,
   parameter int RST_DLY    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk_100M,
   input  logic             rst_n,
   input  logic             ccd_sh,
   input  logic             ccd_rs,
   input  logic             ccd_cp,
   input  logic [ADC_W-1:0] adc_data,
   output logic [ADC_W-1:0] pix_data,
   output logic             pix_valid,
   input  logic             pix_ready,
   output logic             pix_sol,
   output logic             pix_eol,
   output logic             ovf,
   output logic             line_err,
   input  logic             err_clr
);

   localparam int               CNT_W     = $clog2(DUMMY_LEAD + ACTIVE_PIX + 1);
   localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(DUMMY_LEAD - 1);
   localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(ACTIVE_PIX - 1);
   localparam cap_state_t       START_ST  = (DUMMY_LEAD == 0) ? ACTIVE : LEAD;

   cap_state_t       state_q, state_d;
   logic             sh_q, sh_prev_q, cp_q, cp_prev_q;
   logic             sh_rise, cp_fall, strobe;
   logic [5:0]       smp_cnt_q, smp_cnt_d;
   logic             smp_busy_q, smp_busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_req, sol_req, eol_req, restart_err;
   logic             ovf_q, ovf_d, line_err_q, line_err_d;
   logic             vld_p0_q;
   logic [ADC_W-1:0] samp_p0_q;
   logic             sol_p0_q, eol_p0_q;
   pix_word_t        fifo_wr, fifo_rd;
   logic             fifo_push, fifo_full, fifo_empty, pop;

   always_comb begin
      sh_rise    = sh_q && !sh_prev_q;
      cp_fall    = cp_prev_q && !cp_q;
      smp_cnt_d  = smp_cnt_q;
      smp_busy_d = smp_busy_q;
      strobe     = 1'b0;
      // A new cp fall always reloads, abandoning any sample still pending.
      if (cp_fall) begin
         if (SAMPLE_DLY == 0) begin
            strobe     = 1'b1;
            smp_busy_d = 1'b0;
         end else begin
            smp_cnt_d  = 6'(SAMPLE_DLY);
            smp_busy_d = 1'b1;
         end
      end else if (smp_busy_q) begin
         smp_cnt_d = smp_cnt_q - 6'd1;
         if (smp_cnt_q == 6'd1) begin
            strobe     = 1'b1;
            smp_busy_d = 1'b0;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      push_req    = 1'b0;
      sol_req     = 1'b0;
      eol_req     = 1'b0;
      restart_err = 1'b0;
      if (sh_rise) begin
         restart_err = (state_q == ACTIVE);
         state_d     = START_ST;
         cnt_d       = '0;
      end else if (strobe) begin
         case (state_q)
            LEAD: begin
               if (cnt_q == LEAD_LAST) begin
                  state_d = ACTIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ACTIVE: begin
               push_req = 1'b1;
               sol_req  = (cnt_q == '0);
               eol_req  = (cnt_q == ACT_LAST);
               if (eol_req) state_d = TAIL;
               else         cnt_d   = cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      pop        = !fifo_empty && pix_ready;
      ovf_d      = err_clr ? 1'b0 : ovf_q;
      line_err_d = err_clr ? 1'b0 : line_err_q;
      if (fifo_push && fifo_full && !pop) ovf_d = 1'b1;
      if (restart_err) line_err_d = 1'b1;
   end

   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         sh_q       <= 1'b0;
         sh_prev_q  <= 1'b0;
         cp_q       <= 1'b0;
         cp_prev_q  <= 1'b0;
         smp_cnt_q  <= '0;
         smp_busy_q <= 1'b0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         line_err_q <= 1'b0;
         vld_p0_q   <= 1'b0;
      end else begin
         sh_q       <= ccd_sh;
         sh_prev_q  <= sh_q;
         cp_q       <= ccd_cp;
         cp_prev_q  <= cp_q;
         smp_cnt_q  <= smp_cnt_d;
         smp_busy_q <= smp_busy_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         line_err_q <= line_err_d;
         vld_p0_q   <= push_req;
      end
   end

   // p0: signal sample taken on the strobe
   always_ff @(posedge clk_100M) begin
      if (push_req) begin
         samp_p0_q <= adc_data;
         sol_p0_q  <= sol_req;
         eol_p0_q  <= eol_req;
      end
   end

`ifdef CCD_CDS_EN
   logic             rs_q, rs_prev_q, rs_fall, rs_strobe;
   logic [5:0]       rst_cnt_q, rst_cnt_d;
   logic             rst_busy_q, rst_busy_d;
   logic [ADC_W-1:0] rst_lvl_q;
   logic             vld_p1_q;
   logic [ADC_W-1:0] pix_p1_q;
   logic             sol_p1_q, eol_p1_q;

   function automatic logic [ADC_W-1:0] sat_sub(input logic [ADC_W-1:0] lvl,
                                               input logic [ADC_W-1:0] sig);
      logic signed [ADC_W:0] diff;
      diff = $signed({1'b0, lvl}) - $signed({1'b0, sig});
      return diff[ADC_W] ? '0 : diff[ADC_W-1:0];
   endfunction

   always_comb begin
      rs_fall    = rs_prev_q && !rs_q;
      rst_cnt_d  = rst_cnt_q;
      rst_busy_d = rst_busy_q;
      rs_strobe  = 1'b0;
      if (rs_fall) begin
         if (RST_DLY == 0) begin
            rs_strobe  = 1'b1;
            rst_busy_d = 1'b0;
         end else begin
            rst_cnt_d  = 6'(RST_DLY);
            rst_busy_d = 1'b1;
         end
      end else if (rst_busy_q) begin
         rst_cnt_d = rst_cnt_q - 6'd1;
         if (rst_cnt_q == 6'd1) begin
            rs_strobe  = 1'b1;
            rst_busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         rs_q       <= 1'b0;
         rs_prev_q  <= 1'b0;
         rst_cnt_q  <= '0;
         rst_busy_q <= 1'b0;
         vld_p1_q   <= 1'b0;
      end else begin
         rs_q       <= ccd_rs;
         rs_prev_q  <= rs_q;
         rst_cnt_q  <= rst_cnt_d;
         rst_busy_q <= rst_busy_d;
         vld_p1_q   <= vld_p0_q;
      end
   end

   // p1: reset level minus signal, clipped at zero
   always_ff @(posedge clk_100M) begin
      if (rs_strobe) rst_lvl_q <= adc_data;
      if (vld_p0_q) begin
         pix_p1_q <= sat_sub(rst_lvl_q, samp_p0_q);
         sol_p1_q <= sol_p0_q;
         eol_p1_q <= eol_p0_q;
      end
   end

   assign fifo_push = vld_p1_q;
   assign fifo_wr   = '{data: CCD_ADC_W'(pix_p1_q), sol: sol_p1_q, eol: eol_p1_q};
`else
   logic unused_ok;
   assign unused_ok = &{1'b0, ccd_rs, 6'(RST_DLY)};
   assign fifo_push = vld_p0_q;
   assign fifo_wr   = '{data: CCD_ADC_W'(samp_p0_q), sol: sol_p0_q, eol: eol_p0_q};
`endif

   ccd_pix_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_100M (clk_100M),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .pop      (pop),
      .wr_word  (fifo_wr),
      .rd_word  (fifo_rd),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign pix_valid = !fifo_empty;
   assign pix_data  = fifo_empty ? '0 : ADC_W'(fifo_rd.data);
   assign pix_sol   = !fifo_empty && fifo_rd.sol;
   assign pix_eol   = !fifo_empty && fifo_rd.eol;
   assign ovf       = ovf_q;
   assign line_err  = line_err_q;

endmodule
